mem_io_arbiter: RTL and testbench
=================================

Name: mem_io_arbiter

Overview:
- Shares the single-port data block RAM and the keyboard/button/LED I/O space between two requesters: the CPU load/store stage and the UART program loader.
- Decodes CPU addresses into a memory or an I/O region.
- Sequences multi-cycle memory reads, stalling the CPU while it waits.
- Synchronises switch/button inputs and holds the LED output register.
- Sits between the execute/memory stage and the data RAM, replacing ad-hoc ioRead/ioWrite steering.

Parameters:
- MEM_LAT, 1, block-RAM read latency in cycles (1..4).
- IO_BASE, 32'hFFFF_FC00, first I/O address; any address >= IO_BASE is I/O.
- LED_ADDR, 32'hFFFF_FC60, I/O address of the LED register.
- SW_ADDR, 32'hFFFF_FC70, I/O address returning {kdata,bdata}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until served.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address from alu_result.
- cpu_wdata  in  32  store data from the register file.
- cpu_rdata  out  32  load result to the register file.
- cpu_stall  out  1  freeze the pipeline this cycle.
- ld_req  in  1  loader write request.
- ld_addr  in  14  loader word address.
- ld_wdata  in  32  loader data.
- ld_ack  out  1  one-cycle pulse: loader write accepted.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  14  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.
- kdata  in  16  raw switches, asynchronous.
- bdata  in  16  raw buttons, asynchronous.
- led_out  out  16  LED register.

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - state to IDLE, wait counter to 0;
  - cpu_rdata, led_out and the synchroniser flops to 0;
  - cpu_stall, ld_ack, mem_en and mem_we to 0.
- Word address is cpu_addr[15:2]. Bits [1:0] are ignored; all accesses are word accesses.
- Switch and button inputs pass through two flops. The software-visible value lags the pins by 2 cycles.
- States: IDLE, RD_WAIT, RD_DONE.
- IDLE, priority order (the loader always beats the CPU):
  1. ld_req=1: mem_en=mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata, ld_ack=1 in the same cycle. If cpu_req is also 1, cpu_stall=1 that cycle. Stay in IDLE.
  2. cpu_req, cpu_we=1, memory region: a single-cycle write using the CPU fields. cpu_stall=0.
  3. cpu_req, cpu_we=1, I/O region: if the address equals LED_ADDR, led_out <= cpu_wdata[15:0] at the edge. Other I/O addresses are silently dropped. No RAM access, cpu_stall=0.
  4. cpu_req, cpu_we=0, I/O region: cpu_rdata <= {sync kdata, sync bdata} if the address equals SW_ADDR, otherwise 32'h0. Registered at the edge, cpu_stall=0. Data is valid the cycle after the request, matching the RAM path.
  5. cpu_req, cpu_we=0, memory region: mem_en=1, addr driven, cpu_stall=1, counter <= MEM_LAT-1, go to RD_WAIT.
- RD_WAIT:
  - mem_en=1, the same address is held from a registered copy, cpu_stall=1.
  - Counter decrements each cycle. When it is 0, capture cpu_rdata <= mem_rdata and go to RD_DONE.
- RD_DONE:
  - cpu_stall=0, RAM idle. The CPU consumes cpu_rdata this cycle. Next state is IDLE.
  - A new request is not served in this cycle. The minimum load-to-load spacing is MEM_LAT+2 cycles.
- A ld_req arriving during RD_WAIT or RD_DONE waits; ld_ack stays 0 until IDLE. No loader write ever corrupts an in-flight read.
- Requests are level-sensitive and are not latched. A request dropped by the CPU before service is lost.
- Reset mid-read: the FSM returns to IDLE and nothing is written.
- ld_ack and mem_we are never both asserted for a CPU access.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, RD_WAIT=2'd1, RD_DONE=2'd2);
  - IO_BASE, LED_ADDR and SW_ADDR;
  - the memory word-address width (14).
- One natural sub-module: io_sync2, a parameterised-width two-flop synchroniser with async active-low reset, instantiated for {kdata,bdata}.

Test Plan:
- Reset release with kdata=16'h1234, bdata=16'h00FF → after 3 cycles a load from SW_ADDR returns 32'h1234_00FF with no stall; led_out stays 0.
- Load from 0x0000_0040 with MEM_LAT=1 → mem_addr=16; stall for 2 cycles; cpu_rdata equals mem_rdata captured in the RD_WAIT cycle; stall drops in RD_DONE.
- Store 32'hDEAD_BEEF to LED_ADDR → led_out=16'hBEEF next cycle; mem_en stays 0.
- Store to 0x0000_0010 → one-cycle mem_we, mem_addr=4, mem_wdata=cpu_wdata; cpu_stall never asserts.
- ld_req and a CPU store in the same cycle → loader written, ld_ack=1, cpu_stall=1; the CPU store completes the following cycle.
- ld_req during RD_WAIT with MEM_LAT=3 → ld_ack is held off until IDLE and the read data is intact. Separately, rst_n pulsed low mid-RD_WAIT returns all outputs to reset values immediately.

Source files
------------

// File: rtl/mem_io_arbiter_pkg.sv
// Shared state encoding, address map and widths for the data-RAM / I/O arbiter.
package mem_io_arbiter_pkg;

    localparam int unsigned MEM_AW   = 14;
    localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } arb_state_t;

    function automatic logic is_io(input logic [31:0] addr);
        return (addr >= IO_BASE);
    endfunction

endpackage

// File: rtl/mem_io_arbiter_if.sv
// Bundle of the CPU, loader, RAM and switch/LED signals around the arbiter.
interface mem_io_arbiter_if;
    import mem_io_arbiter_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              ld_req;
    logic [MEM_AW-1:0] ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [15:0]       kdata;
    logic [15:0]       bdata;
    logic [15:0]       led_out;

    // Requesters, RAM and board pins
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_wdata,
        output mem_rdata, kdata, bdata,
        input  cpu_rdata, cpu_stall, ld_ack, mem_en, mem_we, mem_addr, mem_wdata, led_out
    );

    // The arbiter itself
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_wdata,
        input  mem_rdata, kdata, bdata,
        output cpu_rdata, cpu_stall, ld_ack, mem_en, mem_we, mem_addr, mem_wdata, led_out
    );

endinterface

// File: rtl/mem_io_arbiter_io_sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
module io_sync2 #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the raw pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/mem_io_arbiter.sv
// Arbitrates the data RAM and the switch/LED space between the CPU and the loader.
module mem_io_arbiter
    import mem_io_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_io_arbiter_if.slave  bus
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    arb_state_t        state_r;
    arb_state_t        next_s;
    logic [1:0]        cnt_r;
    logic [MEM_AW-1:0] addr_r;
    logic [31:0]       cpu_rdata_r;
    logic [15:0]       led_r;
    logic [31:0]       sw_s;
    logic [MEM_AW-1:0] cpu_waddr_s;
    logic              io_s;
    logic              stall_s;
    logic              ack_s;
    logic              en_s;
    logic              we_s;
    logic [MEM_AW-1:0] maddr_s;
    logic [31:0]       mwdata_s;
    logic              led_we_s;
    logic              io_rd_s;
    logic              rd_start_s;
    logic              capture_s;

    assign cpu_waddr_s = bus.cpu_addr[MEM_AW+1:2];
    assign io_s        = is_io(bus.cpu_addr);

    io_sync2 #(.W(32)) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.kdata, bus.bdata}),
        .q     (sw_s)
    );

    // Next state and RAM/handshake steering; gated by rst_n so outputs drop at once
    always_comb begin
        next_s     = state_r;
        stall_s    = 1'b0;
        ack_s      = 1'b0;
        en_s       = 1'b0;
        we_s       = 1'b0;
        maddr_s    = cpu_waddr_s;
        mwdata_s   = bus.cpu_wdata;
        led_we_s   = 1'b0;
        io_rd_s    = 1'b0;
        rd_start_s = 1'b0;
        capture_s  = 1'b0;
        if (!rst_n) begin
            next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.ld_req) begin
                        en_s     = 1'b1;
                        we_s     = 1'b1;
                        maddr_s  = bus.ld_addr;
                        mwdata_s = bus.ld_wdata;
                        ack_s    = 1'b1;
                        stall_s  = bus.cpu_req;
                    end else if (bus.cpu_req) begin
                        if (bus.cpu_we) begin
                            if (io_s) begin
                                led_we_s = (bus.cpu_addr == LED_ADDR);
                            end else begin
                                en_s = 1'b1;
                                we_s = 1'b1;
                            end
                        end else begin
                            if (io_s) begin
                                io_rd_s = 1'b1;
                            end else begin
                                en_s       = 1'b1;
                                stall_s    = 1'b1;
                                rd_start_s = 1'b1;
                                next_s     = RD_WAIT;
                            end
                        end
                    end else begin
                        next_s = IDLE;
                    end
                end
                RD_WAIT: begin
                    en_s    = 1'b1;
                    maddr_s = addr_r;
                    stall_s = 1'b1;
                    if (cnt_r == 2'd0) begin
                        capture_s = 1'b1;
                        next_s    = RD_DONE;
                    end else begin
                        next_s = RD_WAIT;
                    end
                end
                RD_DONE: begin
                    next_s = IDLE;
                end
                default: begin
                    next_s = IDLE;
                end
            endcase
        end
    end

    // State, wait counter, held read address and the registered CPU-visible outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            addr_r      <= {MEM_AW{1'b0}};
            cpu_rdata_r <= 32'h0000_0000;
            led_r       <= 16'h0000;
        end else begin
            state_r <= next_s;
            if (rd_start_s) begin
                cnt_r  <= CNT_INIT;
                addr_r <= cpu_waddr_s;
            end else if ((state_r == RD_WAIT) && (cnt_r != 2'd0)) begin
                cnt_r <= cnt_r - 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (capture_s) begin
                cpu_rdata_r <= bus.mem_rdata;
            end else if (io_rd_s) begin
                cpu_rdata_r <= (bus.cpu_addr == SW_ADDR) ? sw_s : 32'h0000_0000;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (led_we_s) begin
                led_r <= bus.cpu_wdata[15:0];
            end else begin
                led_r <= led_r;
            end
        end
    end

    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.led_out   = led_r;
    assign bus.cpu_stall = stall_s;
    assign bus.ld_ack    = ack_s;
    assign bus.mem_en    = en_s;
    assign bus.mem_we    = we_s;
    assign bus.mem_addr  = maddr_s;
    assign bus.mem_wdata = mwdata_s;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Scoreboard bench: one arbiter with 1-cycle RAM latency, one with 3-cycle latency.
module tb_mem_io_arbiter;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    localparam logic [31:0] T_IO_BASE = 32'hFFFF_FC00;
    localparam logic [31:0] T_LED     = 32'hFFFF_FC60;
    localparam logic [31:0] T_SW      = 32'hFFFF_FC70;
    localparam logic [31:0] GARB      = 32'hBAD0_BAD0;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cur3      = 1'b0;
    logic        cpu_req   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [31:0] cpu_addr  = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        ld_req    = 1'b0;
    logic [13:0] ld_addr   = 14'h0;
    logic [31:0] ld_wdata  = 32'h0;
    logic [15:0] kdata     = 16'h1234;
    logic [15:0] bdata     = 16'h00FF;
    logic [31:0] p1;
    logic [31:0] p3 [3];
    int          errors    = 0;
    int          checks    = 0;
    logic [31:0] exp_rd_q [$];
    wr_t         wr_q [$];

    mem_io_arbiter_if if1 ();
    mem_io_arbiter_if if3 ();

    assign if1.cpu_req   = cpu_req & ~cur3;
    assign if3.cpu_req   = cpu_req & cur3;
    assign if1.ld_req    = ld_req & ~cur3;
    assign if3.ld_req    = ld_req & cur3;
    assign if1.cpu_we    = cpu_we;
    assign if3.cpu_we    = cpu_we;
    assign if1.cpu_addr  = cpu_addr;
    assign if3.cpu_addr  = cpu_addr;
    assign if1.cpu_wdata = cpu_wdata;
    assign if3.cpu_wdata = cpu_wdata;
    assign if1.ld_addr   = ld_addr;
    assign if3.ld_addr   = ld_addr;
    assign if1.ld_wdata  = ld_wdata;
    assign if3.ld_wdata  = ld_wdata;
    assign if1.kdata     = kdata;
    assign if3.kdata     = kdata;
    assign if1.bdata     = bdata;
    assign if3.bdata     = bdata;
    assign if1.mem_rdata = p1;
    assign if3.mem_rdata = p3[2];

    mem_io_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mem_io_arbiter #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;

    logic        cur_stall, cur_ack, cur_en, cur_we;
    logic [13:0] cur_maddr;
    logic [31:0] cur_mwdata, cur_rdata;
    logic [15:0] cur_led;
    assign cur_stall  = cur3 ? if3.cpu_stall : if1.cpu_stall;
    assign cur_ack    = cur3 ? if3.ld_ack    : if1.ld_ack;
    assign cur_en     = cur3 ? if3.mem_en    : if1.mem_en;
    assign cur_we     = cur3 ? if3.mem_we    : if1.mem_we;
    assign cur_maddr  = cur3 ? if3.mem_addr  : if1.mem_addr;
    assign cur_mwdata = cur3 ? if3.mem_wdata : if1.mem_wdata;
    assign cur_rdata  = cur3 ? if3.cpu_rdata : if1.cpu_rdata;
    assign cur_led    = cur3 ? if3.led_out   : if1.led_out;

    function automatic logic [31:0] pat(input logic [13:0] a);
        return {18'h3C0DE, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // RAM read pipelines: data appears MEM_LAT cycles after an enabled read, garbage otherwise
    always @(posedge clk) begin
        p1    <= (if1.mem_en && !if1.mem_we) ? pat(if1.mem_addr) : GARB;
        p3[0] <= (if3.mem_en && !if3.mem_we) ? pat(if3.mem_addr) : GARB;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    // Write monitor: every RAM write of the active DUT must match the next expected write
    always @(negedge clk) begin
        if (rst_n && cur_en && cur_we) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(cur_maddr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(cur_maddr), 32'(e.a));
                check("wr_data", cur_mwdata, e.d);
            end
        end
    end

    task automatic cpu_load(input logic [31:0] addr, input logic [31:0] exp, input int exp_stall);
        int n;
        n = 0;
        @(posedge clk); #1;
        exp_rd_q.push_back(exp);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        @(negedge clk);
        if (cur_stall) check("ld_maddr", 32'(cur_maddr), 32'(addr[15:2]));
        while (cur_stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("ld_stall_cycles", 32'(n), 32'(exp_stall));
        if (n == 0) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            @(negedge clk);
        end else begin
            check("ld_done_mem_en", 32'(cur_en), 32'h0);
            cpu_req = 1'b0;
        end
        check("ld_rdata", cur_rdata, exp_rd_q.pop_front());
    endtask

    task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
        logic io;
        io = (addr >= T_IO_BASE);
        @(posedge clk); #1;
        if (!io) wr_q.push_back(wr_t'{a: addr[15:2], d: data});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data;
        @(negedge clk);
        check("st_stall", 32'(cur_stall), 32'h0);
        check("st_mem_en", 32'(cur_en), 32'(!io));
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic ld_write(input logic [13:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_q.push_back(wr_t'{a: a, d: d});
        ld_req = 1'b1; ld_addr = a; ld_wdata = d;
        @(negedge clk);
        check("ld_ack", 32'(cur_ack), 32'h1);
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk);
        check("ld_ack_pulse", 32'(cur_ack), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Requests held during reset must not leak through to any output
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
        ld_req = 1'b1; ld_addr = 14'h0055;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(cur_stall), 32'h0);
        check("rst_ack", 32'(cur_ack), 32'h0);
        check("rst_mem_en", 32'(cur_en), 32'h0);
        check("rst_mem_we", 32'(cur_we), 32'h0);
        check("rst_rdata", cur_rdata, 32'h0);
        check("rst_led", 32'(cur_led), 32'h0);
        cpu_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        cpu_load(T_SW, 32'h1234_00FF, 0);
        check("sw_led_zero", 32'(cur_led), 32'h0);
        cpu_load(32'h0000_0040, pat(14'd16), 2);
        cpu_load(32'h0000_0043, pat(14'd16), 2);
        cpu_load(32'hFFFF_FC10, 32'h0, 0);
        cpu_store(T_LED, 32'hDEAD_BEEF);
        @(negedge clk);
        check("led_write", 32'(cur_led), 32'h0000_BEEF);
        cpu_store(32'hFFFF_FC64, 32'h1111_2222);
        @(negedge clk);
        check("led_other_io", 32'(cur_led), 32'h0000_BEEF);
        cpu_store(32'h0000_0010, 32'hCAFE_F00D);
        cpu_store(32'hFFFF_FBFC, 32'h0BAD_F00D);
        ld_write(14'h0123, 32'h5A5A_0001);

        // Loader and CPU store in the same cycle: loader first, CPU next cycle
        @(posedge clk); #1;
        wr_q.push_back(wr_t'{a: 14'h0200, d: 32'h1357_9BDF});
        wr_q.push_back(wr_t'{a: 14'd8, d: 32'h2468_ACE0});
        ld_req = 1'b1; ld_addr = 14'h0200; ld_wdata = 32'h1357_9BDF;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'h2468_ACE0;
        @(negedge clk);
        check("both_ack", 32'(cur_ack), 32'h1);
        check("both_stall", 32'(cur_stall), 32'h1);
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(negedge clk);
        check("both_ack2", 32'(cur_ack), 32'h0);
        check("both_stall2", 32'(cur_stall), 32'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;

        // Switch to the MEM_LAT=3 instance
        @(posedge clk); #1;
        cur3 = 1'b1;
        cpu_store(T_LED, 32'h0000_A5A5);
        @(negedge clk);
        check("led3_write", 32'(cur_led), 32'h0000_A5A5);
        cpu_load(32'h0000_0100, pat(14'd64), 4);

        // Loader request arriving during RD_WAIT is held off until IDLE
        @(posedge clk); #1;
        exp_rd_q.push_back(pat(14'd80));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0140;
        @(negedge clk);
        check("rw_idle_stall", 32'(cur_stall), 32'h1);
        @(posedge clk); #1;
        wr_q.push_back(wr_t'{a: 14'h0321, d: 32'hFEED_0003});
        ld_req = 1'b1; ld_addr = 14'h0321; ld_wdata = 32'hFEED_0003;
        n = 1;
        @(negedge clk);
        while (cur_stall && n < 40) begin
            check("rw_ack_hold", 32'(cur_ack), 32'h0);
            n++;
            @(negedge clk);
        end
        check("rw_stall_cycles", 32'(n), 32'd4);
        check("rw_done_ack", 32'(cur_ack), 32'h0);
        check("rw_rdata", cur_rdata, exp_rd_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clk);
        check("rw_ack_idle", 32'(cur_ack), 32'h1);
        @(posedge clk); #1;
        ld_req = 1'b0;

        // Reset pulsed in the middle of RD_WAIT
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
        @(negedge clk);
        check("mr_idle_stall", 32'(cur_stall), 32'h1);
        @(posedge clk); #1;
        ld_req = 1'b1; ld_addr = 14'h0111; ld_wdata = 32'h7777_7777;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_stall", 32'(cur_stall), 32'h0);
        check("mr_mem_en", 32'(cur_en), 32'h0);
        check("mr_ack", 32'(cur_ack), 32'h0);
        check("mr_rdata", cur_rdata, 32'h0);
        check("mr_led", 32'(cur_led), 32'h0);
        cpu_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_load(32'h0000_0204, pat(14'd129), 4);

        @(posedge clk); #1;
        check("wr_q_drained", 32'(wr_q.size()), 32'h0);
        check("rd_q_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
